// File: rtl/sdram_client_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : sdram_client_arbiter_if
// Desc      : SDRAMBus request/finished signal bundle (arbiter = master).
// Revision  : 1.0 - initial release
// ============================================================================
interface sdram_client_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic              sdram_read;
  logic              sdram_write;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_writedata;
  logic [DATA_W-1:0] sdram_readdata;
  logic              sdram_finished;

  modport master (
    output sdram_read, sdram_write, sdram_addr, sdram_writedata,
    input  sdram_readdata, sdram_finished
  );

  modport slave (
    input  sdram_read, sdram_write, sdram_addr, sdram_writedata,
    output sdram_readdata, sdram_finished
  );
endinterface
`default_nettype wire

// File: rtl/sdram_client_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_client_arbiter
// Desc     : Arbitrates NUM_CLIENTS cores onto one SDRAM request/finished bus
//            (locked-select, fixed priority, round-robin).
//            Optional macro SDRAM_ARB_TIMEOUT_EN: BUSY watchdog + cli_error.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_client_arbiter #(
  parameter int NUM_CLIENTS = 5,
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 32,
  parameter int SEL_W       = $clog2(NUM_CLIENTS),
  parameter int TIMEOUT     = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [1:0]                    arb_mode,
  input  logic [SEL_W-1:0]              arb_sel,
  input  logic [NUM_CLIENTS-1:0]        cli_read,
  input  logic [NUM_CLIENTS-1:0]        cli_write,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_writedata,
  output logic [DATA_W-1:0]             cli_readdata,
  output logic [NUM_CLIENTS-1:0]        cli_finished,
  output logic [NUM_CLIENTS-1:0]        cli_error,
  output logic                          grant_valid,
  output logic [SEL_W-1:0]              grant_idx,
  sdram_client_arbiter_if.master        sdram
);

  localparam logic [1:0] c_MODE_LOCKED = 2'd0;
  localparam logic [1:0] c_MODE_FIXED  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  logic [SEL_W-1:0]         r_grant_idx;
  logic                     r_grant_valid;
  logic [SEL_W-1:0]         r_rr_ptr;
  logic                     r_rr_grant;
  logic                     r_sdram_read;
  logic                     r_sdram_write;
  logic [ADDR_W-1:0]        r_sdram_addr;
  logic [DATA_W-1:0]        r_sdram_wdata;
  logic [DATA_W-1:0]        r_cli_readdata;
  logic [NUM_CLIENTS-1:0]   r_cli_finished;

  logic [NUM_CLIENTS-1:0]   w_pending;
  logic [NUM_CLIENTS-1:0]   w_grant_onehot;
  logic                     w_win_valid;
  logic [SEL_W-1:0]         w_win_idx;

  assign w_pending      = cli_read | cli_write;
  assign w_grant_onehot = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << r_grant_idx;

  // Illegal configurations leave this block populated for easy spotting.
  if (NUM_CLIENTS < 2 || NUM_CLIENTS > 16 || TIMEOUT < 1) begin : g_bad_config
  end

  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    case (arb_mode)
      c_MODE_LOCKED: begin
        if ((int'(arb_sel) < NUM_CLIENTS) && w_pending[arb_sel]) begin
          w_win_valid = 1'b1;
          w_win_idx   = arb_sel;
        end
      end
      c_MODE_FIXED: begin
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
          if (w_pending[i]) begin
            w_win_valid = 1'b1;
            w_win_idx   = SEL_W'(i);
          end
        end
      end
      default: begin
        // Scan backwards so the nearest pending index after the pointer wins.
        for (int k = NUM_CLIENTS; k >= 1; k--) begin
          if (w_pending[(int'(r_rr_ptr) + k) % NUM_CLIENTS]) begin
            w_win_valid = 1'b1;
            w_win_idx   = SEL_W'((int'(r_rr_ptr) + k) % NUM_CLIENTS);
          end
        end
      end
    endcase
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT + 1);

  logic [c_TO_W-1:0]      r_to_cnt;
  logic [NUM_CLIENTS-1:0] r_cli_error;

  assign cli_error = r_cli_error;
`else
  assign cli_error = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state        <= ST_IDLE;
      r_grant_idx    <= '0;
      r_grant_valid  <= 1'b0;
      r_rr_ptr       <= SEL_W'(NUM_CLIENTS - 1);
      r_rr_grant     <= 1'b0;
      r_sdram_read   <= 1'b0;
      r_sdram_write  <= 1'b0;
      r_sdram_addr   <= '0;
      r_sdram_wdata  <= '0;
      r_cli_readdata <= '0;
      r_cli_finished <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      r_to_cnt       <= '0;
      r_cli_error    <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_state       <= ST_BUSY;
            r_grant_valid <= 1'b1;
            r_grant_idx   <= w_win_idx;
            r_rr_grant    <= arb_mode[1];
            r_sdram_addr  <= cli_addr[w_win_idx*ADDR_W +: ADDR_W];
            r_sdram_wdata <= cli_writedata[w_win_idx*DATA_W +: DATA_W];
            r_sdram_write <= cli_write[w_win_idx];
            r_sdram_read  <= ~cli_write[w_win_idx];
`ifdef SDRAM_ARB_TIMEOUT_EN
            r_to_cnt      <= '0;
`endif
          end
        end
        ST_BUSY: begin
          if (sdram.sdram_finished) begin
            if (r_sdram_read) begin
              r_cli_readdata <= sdram.sdram_readdata;
            end
            r_sdram_read   <= 1'b0;
            r_sdram_write  <= 1'b0;
            r_cli_finished <= w_grant_onehot;
            r_state        <= ST_DONE;
          end
`ifdef SDRAM_ARB_TIMEOUT_EN
          else if (r_to_cnt == c_TO_W'(TIMEOUT - 1)) begin
            r_sdram_read   <= 1'b0;
            r_sdram_write  <= 1'b0;
            r_cli_finished <= w_grant_onehot;
            r_cli_error    <= w_grant_onehot;
            r_state        <= ST_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          // Extra cycle lets the finished client drop its request first.
          r_cli_finished <= '0;
          r_grant_valid  <= 1'b0;
          r_state        <= ST_IDLE;
          if (r_rr_grant) begin
            r_rr_ptr <= r_grant_idx;
          end
`ifdef SDRAM_ARB_TIMEOUT_EN
          r_cli_error    <= '0;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sdram.sdram_read      = r_sdram_read;
  assign sdram.sdram_write     = r_sdram_write;
  assign sdram.sdram_addr      = r_sdram_addr;
  assign sdram.sdram_writedata = r_sdram_wdata;
  assign cli_readdata          = r_cli_readdata;
  assign cli_finished          = r_cli_finished;
  assign grant_valid           = r_grant_valid;
  assign grant_idx             = r_grant_idx;

endmodule
`default_nettype wire

// File: doc/sdram_client_arbiter.md
Name: sdram_client_arbiter

Overview:
Parametrised successor to the fixed five-way SDRAM mux in the audio core top level. It arbitrates N client cores (record, play, mix, pitch, loader, ...) onto the single SDRAMBus request/finished interface. It supports three modes: locked-select (legacy control_mode behaviour), fixed priority and round-robin. Each grant is held for one complete SDRAM transaction, and the SDRAM finished pulse and read data are returned only to the granted client.

Parameters:
NUM_CLIENTS, 5, number of requesting cores (2..16)
ADDR_W, 23, SDRAM word address width
DATA_W, 32, SDRAM data width
SEL_W, $clog2(NUM_CLIENTS), width of client index
TIMEOUT, 1024, cycles to wait for sdram_finished before abort (used only with the optional feature)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-low reset
arb_mode  in  2  0=locked to arb_sel, 1=fixed priority (index 0 highest), 2/3=round-robin
arb_sel  in  SEL_W  client index used in locked mode
cli_read  in  NUM_CLIENTS  per-client read request (level)
cli_write  in  NUM_CLIENTS  per-client write request (level)
cli_addr  in  NUM_CLIENTS*ADDR_W  packed addresses; client i occupies slice [i*ADDR_W +: ADDR_W]
cli_writedata  in  NUM_CLIENTS*DATA_W  packed write data
cli_readdata  out  DATA_W  shared read-data register; valid when cli_finished[i]=1
cli_finished  out  NUM_CLIENTS  one-hot, one-cycle completion pulse
cli_error  out  NUM_CLIENTS  one-cycle timeout pulse, coincident with cli_finished
grant_valid  out  1  a transaction is in flight
grant_idx  out  SEL_W  index of current or last grant
sdram_read  out  1  to SDRAMBus
sdram_write  out  1  to SDRAMBus
sdram_addr  out  ADDR_W  to SDRAMBus
sdram_writedata  out  DATA_W  to SDRAMBus
sdram_readdata  in  DATA_W  from SDRAMBus
sdram_finished  in  1  from SDRAMBus, one-cycle done pulse

Behaviour:
- Reset (i_rst=0, asynchronous): state=IDLE. All outputs are 0: sdram_*, cli_finished, cli_error, cli_readdata, grant_valid, grant_idx. RR pointer = NUM_CLIENTS-1, so client 0 is first in round-robin. Reset mid-transaction abandons the transaction; no finished pulse is produced.
- Request i is pending when cli_read[i] | cli_write[i]. Clients hold requests until their cli_finished pulse and drop them the next cycle.
- If both read and write are set for a client, the transaction is a write.
- FSM states: IDLE, BUSY, DONE.
- IDLE: arb_mode is sampled here only. The winner is chosen combinationally:
  - locked: arb_sel if pending, else none; out-of-range arb_sel means none.
  - fixed: lowest pending index.
  - RR: first pending index after the pointer, wrapping modulo NUM_CLIENTS.
- IDLE with a winner: register grant_idx, addr, writedata and read/write → BUSY. sdram_read/sdram_write go high the cycle after the request is seen (1-cycle grant latency).
- BUSY: sdram_* outputs are registered and held stable; client inputs are ignored after capture. On sdram_finished: capture sdram_readdata into cli_readdata (reads only; writes leave it unchanged), deassert sdram_read/write, go to DONE.
- DONE (exactly 1 cycle): cli_finished[grant_idx]=1. In RR mode the pointer is set to grant_idx. Next state is IDLE. This extra cycle guarantees a client's dropped request is never re-granted.
- Minimum turnaround: 3 cycles per transaction plus SDRAM latency. Back-to-back grants to different clients are possible from the IDLE following DONE.
- Requests that change during BUSY/DONE have no effect. A mode change during BUSY takes effect at the next IDLE.
- grant_valid=1 in BUSY and DONE.
- Round-robin fairness: with all clients pending continuously, each is granted once per NUM_CLIENTS transactions.
- sdram_finished arriving in IDLE or DONE is ignored.

Optional Feature:
SDRAM_ARB_TIMEOUT_EN
- Defined: a counter runs in BUSY. If TIMEOUT cycles elapse without sdram_finished, sdram_read/write drop and the FSM goes to DONE. In DONE, cli_finished and cli_error for the granted client pulse together and cli_readdata is left unchanged. An sdram_finished arriving after the abort is ignored.
- Undefined: no counter; BUSY waits indefinitely and cli_error is tied to 0.

Test Plan:
- Single read, client 2, addr 23'h000100; SDRAM finishes 4 cycles after sdram_read rises with data 32'hCAFE0001 → sdram_read high 1 cycle after request, cli_finished=5'b00100 for 1 cycle, cli_readdata=32'hCAFE0001.
- RR mode, clients 0,1,3 holding writes → grant order 0,1,3,0,1,3; no client granted twice consecutively; client 3's sdram_writedata matches its slice.
- Fixed mode, clients 1 and 4 pending, client 1 re-requests immediately → client 1 granted repeatedly, client 4 starves (expected in this mode).
- Locked mode, arb_sel=3 with clients 0 and 3 pending → only client 3 is granted; changing arb_sel to 0 mid-BUSY lets client 0 be granted only after DONE.
- i_rst low during BUSY → sdram_read falls asynchronously, no cli_finished; after release, client 0 wins RR first.
- With SDRAM_ARB_TIMEOUT_EN and TIMEOUT=16, sdram_finished never asserted → after 16 BUSY cycles cli_finished and cli_error pulse for the granted client; a late sdram_finished is ignored.
